sgd_x_updated_stream_out: RTL and testbench



---
 rtl/sgd_x_updated_stream_out_pkg.sv | 9 +
 rtl/sgd_stream_skid_fifo.sv | 37 +++
 rtl/sgd_x_updated_stream_out.sv | 84 ++++++++
 tb/tb_sgd_x_updated_stream_out.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sgd_x_updated_stream_out_pkg.sv
// sgd_x_updated_stream_out_pkg: shared FSM states and word-count helper for the x_updated read-out.
package sgd_x_updated_stream_out_pkg;
  typedef enum logic [2:0] {IDLE, CALC, READ, DRAIN, FIN} state_e;
  function automatic logic [31:0] calc_word_count(input logic [31:0] dim, input int unsigned shift);
    logic [31:0] mask;
    mask = (32'd1 << shift) - 32'd1;
    return (dim >> shift) + {31'd0, (dim & mask) != 32'd0};
  endfunction
endpackage

// File: rtl/sgd_stream_skid_fifo.sv
// sgd_stream_skid_fifo: small circular FIFO absorbing BRAM reads while downstream stalls.
module sgd_stream_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [AW:0]   count_o,
  output logic          empty_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/sgd_x_updated_stream_out.sv
// sgd_x_updated_stream_out: reads every populated x_updated BRAM word and streams it out with last/done.
module sgd_x_updated_stream_out
  import sgd_x_updated_stream_out_pkg::*;
#(
  parameter int LANES = 8,
  parameter int ADDR_W = 10,
  parameter int BANK_SHIFT = 6,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           dimension,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     x_rd_addr,
  input  logic [LANES*32-1:0]   x_rd_data,
  output logic [LANES*32-1:0]   m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [31:0] dim_q, wc_q, issue_q, out_q, wc;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LATENCY-1:0] vsr_q;
  logic [CW-1:0] fifo_cnt, inflight;
  logic [CW:0] credit;
  logic issue, last_issue, push, pop, empty;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vsr_q[i]);
  end
  // Reads in flight plus FIFO occupancy never exceed FIFO_DEPTH, so every returning read has a slot.
  assign credit = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign wc = calc_word_count(dim_q, BANK_SHIFT);
  assign issue = (state_q == READ) && (credit < (CW+1)'(FIFO_DEPTH));
  assign last_issue = issue && (issue_q == wc_q - 32'd1);
  assign push = vsr_q[RD_LATENCY-1];
  assign pop = m_valid && m_ready;
  assign x_rd_addr = issue ? issue_q[ADDR_W-1:0] : addr_q;
  assign m_valid = !empty;
  assign m_last = m_valid && (out_q == wc_q - 32'd1);
  assign busy = state_q inside {CALC, READ, DRAIN};
  assign done = state_q == FIN;
  always_comb begin
    state_d = (state_q == IDLE && start) ? CALC :
              (state_q == CALC) ? ((wc == 32'd0) ? FIN : READ) :
              (state_q == READ && last_issue) ? DRAIN :
              (state_q == DRAIN && pop && m_last) ? FIN :
              (state_q == FIN) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dim_q <= '0;
      wc_q <= '0;
      issue_q <= '0;
      out_q <= '0;
      addr_q <= '0;
      vsr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) dim_q <= dimension;
      if (state_q == CALC) begin
        wc_q <= wc;
        issue_q <= '0;
        out_q <= '0;
      end
      if (issue) begin
        addr_q <= issue_q[ADDR_W-1:0];
        issue_q <= issue_q + 32'd1;
      end
      vsr_q <= (vsr_q << 1) | RD_LATENCY'(issue);
      if (pop) out_q <= out_q + 32'd1;
    end
  end
  sgd_stream_skid_fifo #(.DEPTH(FIFO_DEPTH), .W(LANES*32)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .data_i(x_rd_data),
    .data_o(m_data), .count_o(fifo_cnt), .empty_o(empty)
  );
endmodule

// File: tb/tb_sgd_x_updated_stream_out.sv
// tb_sgd_x_updated_stream_out: directed tests of the x_updated read-out against a 2-cycle BRAM model.
module tb_sgd_x_updated_stream_out;
  localparam int ADDR_W = 10;
  localparam int DW = 256;
  logic clk = 0, rst_n = 0, start = 0, m_ready = 0;
  logic [31:0] dimension = 0;
  logic busy, done, m_valid, m_last;
  logic [ADDR_W-1:0] x_rd_addr;
  logic [DW-1:0] x_rd_data, m_data, s1, s2;
  int checks = 0, failures = 0, epoch = 1;
  logic [DW-1:0] got_d[$];
  bit got_l[$];
  int got_c[$];
  int done_cnt, done_cyc, first_v, stall_bad, ovf, busy_n;
  bit finished;
  logic [ADDR_W-1:0] addr_log[64];

  sgd_x_updated_stream_out dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dimension(dimension), .busy(busy), .done(done),
    .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] bram_word(input logic [ADDR_W-1:0] a, input int ep);
    logic [DW-1:0] w;
    for (int j = 0; j < 8; j++) w[j*32 +: 32] = {8'(ep), 6'd0, a, 8'(j)};
    return w;
  endfunction

  always @(posedge clk) begin
    s1 <= bram_word(x_rd_addr, epoch);
    s2 <= s1;
  end
  assign x_rd_data = s2;

  // cyc 0 is the cycle start is driven; everything recorded per cycle before the next edge.
  task automatic collect(input logic [31:0] dim, input int mode, input int budget, input int restart_cyc);
    logic [DW-1:0] pd;
    bit pl, pstall;
    int cyc;
    if ((dim >> 6) + 32'(dim[5:0] != 0) > 1024) begin
      $display("FAIL illegal_dimension got=%0d", dim);
      $fatal(1, "illegal dimension");
    end
    got_d.delete(); got_l.delete(); got_c.delete();
    done_cnt = 0; done_cyc = -1; first_v = -1; stall_bad = 0; ovf = 0; busy_n = 0;
    finished = 0; pstall = 0; pd = '0; pl = 0; cyc = 0;
    dimension = dim;
    start = 1;
    while (cyc < budget) begin
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(cyc >= 6 && cyc <= 10) : 1'($urandom_range(0, 1));
      if (cyc < 64) addr_log[cyc] = x_rd_addr;
      if (pstall && (m_data !== pd || m_last !== pl)) stall_bad++;
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_c.push_back(cyc);
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy === 1'b1) busy_n++;
      if (dut.push && !dut.pop && dut.fifo_cnt == 4) ovf++;
      pstall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_cyc);
      dimension = start ? 32'd4096 : dim;
      if (done_cnt > 0 && cyc > done_cyc + 4) begin
        finished = 1;
        break;
      end
    end
    start = 0;
    m_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({busy, done, m_valid, m_last} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, m_valid, m_last}); end
    checks++; if (x_rd_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", x_rd_addr); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", m_data); end
    rst_n = 1;
    @(posedge clk); #1;
    checks++; if ({busy, done, m_valid} !== 3'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=000", {busy, done, m_valid}); end
  endtask

  task automatic test_dim130();
    collect(130, 0, 40, -1);
    checks++; if (!finished) begin failures++; $display("FAIL d130_timeout got=0 exp=1"); end
    checks++; if (got_d.size() !== 3) begin failures++; $display("FAIL d130_count got=%0d exp=3", got_d.size()); end
    checks++; if (first_v !== 5) begin failures++; $display("FAIL d130_first_valid got=%0d exp=5", first_v); end
    for (int i = 0; i < got_d.size() && i < 3; i++) begin
      checks++; if (got_d[i] !== bram_word(ADDR_W'(i), epoch)) begin failures++; $display("FAIL d130_data%0d got=%0h exp=%0h", i, got_d[i], bram_word(ADDR_W'(i), epoch)); end
      checks++; if (got_l[i] !== (i == 2)) begin failures++; $display("FAIL d130_last%0d got=%0d exp=%0d", i, got_l[i], i == 2); end
      checks++; if (got_c[i] !== 5 + i) begin failures++; $display("FAIL d130_cycle%0d got=%0d exp=%0d", i, got_c[i], 5 + i); end
    end
    checks++; if (done_cyc !== 8) begin failures++; $display("FAIL d130_done_cycle got=%0d exp=8", done_cyc); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL d130_done_count got=%0d exp=1", done_cnt); end
    checks++; if (busy_n !== 7) begin failures++; $display("FAIL d130_busy_cycles got=%0d exp=7", busy_n); end
  endtask

  task automatic test_dim128_and_zero();
    collect(128, 0, 40, -1);
    checks++; if (got_d.size() !== 2) begin failures++; $display("FAIL d128_count got=%0d exp=2", got_d.size()); end
    checks++; if (got_d.size() == 2 && (got_d[1] !== bram_word(1, epoch) || got_l[1] !== 1'b1 || got_l[0] !== 1'b0)) begin failures++; $display("FAIL d128_last_word got=%0h/%0d exp=%0h/1", got_d[1], got_l[1], bram_word(1, epoch)); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL d128_done_count got=%0d exp=1", done_cnt); end
    collect(0, 0, 20, -1);
    checks++; if (first_v !== -1) begin failures++; $display("FAIL d0_valid got=%0d exp=-1", first_v); end
    checks++; if (done_cyc !== 2) begin failures++; $display("FAIL d0_done_cycle got=%0d exp=2", done_cyc); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL d0_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    collect(512, 1, 80, -1);
    checks++; if (got_d.size() !== 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      checks++; if (got_d[i] !== bram_word(ADDR_W'(i), epoch) || got_l[i] !== (i == 7)) begin failures++; $display("FAIL bp_word%0d got=%0h/%0d exp=%0h/%0d", i, got_d[i], got_l[i], bram_word(ADDR_W'(i), epoch), i == 7); end
    end
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
    checks++; if (ovf !== 0) begin failures++; $display("FAIL bp_overflow got=%0d exp=0", ovf); end
    for (int c = 7; c <= 10; c++) begin
      checks++; if (addr_log[c] !== 10'd4) begin failures++; $display("FAIL bp_addr_hold%0d got=%0d exp=4", c, addr_log[c]); end
    end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random_ready();
    int bad_d, bad_l;
    collect(4096, 2, 600, -1);
    bad_d = 0; bad_l = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== bram_word(ADDR_W'(i), epoch)) bad_d++;
      if (got_l[i] !== (i == 63)) bad_l++;
    end
    checks++; if (got_d.size() !== 64) begin failures++; $display("FAIL rnd_count got=%0d exp=64", got_d.size()); end
    checks++; if (bad_d !== 0) begin failures++; $display("FAIL rnd_data_errors got=%0d exp=0", bad_d); end
    checks++; if (bad_l !== 0) begin failures++; $display("FAIL rnd_last_errors got=%0d exp=0", bad_l); end
    checks++; if (stall_bad !== 0 || ovf !== 0) begin failures++; $display("FAIL rnd_stall_ovf got=%0d/%0d exp=0/0", stall_bad, ovf); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rnd_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    collect(192, 0, 40, 3);
    checks++; if (got_d.size() !== 3) begin failures++; $display("FAIL restart_count got=%0d exp=3", got_d.size()); end
    checks++; if (got_d.size() == 3 && got_l[2] !== 1'b1) begin failures++; $display("FAIL restart_last got=%0d exp=1", got_l[2]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int dn;
    dimension = 128;
    start = 1;
    m_ready = 0;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || m_valid !== 1'b1) begin failures++; $display("FAIL mid_drain_state got=%b exp=11", {busy, m_valid}); end
    rst_n = 0;
    dn = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    rst_n = 1;
    checks++; if ({busy, done, m_valid} !== 3'b0 || dn !== 0) begin failures++; $display("FAIL mid_reset_flush got=%b/%0d exp=000/0", {busy, done, m_valid}, dn); end
    epoch++;
    collect(64, 0, 30, -1);
    checks++; if (got_d.size() !== 1) begin failures++; $display("FAIL mid_count got=%0d exp=1", got_d.size()); end
    checks++; if (got_d.size() == 1 && (got_d[0] !== bram_word(0, epoch) || got_l[0] !== 1'b1)) begin failures++; $display("FAIL mid_word got=%0h/%0d exp=%0h/1", got_d[0], got_l[0], bram_word(0, epoch)); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL mid_done_count got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dim130();
    test_dim128_and_zero();
    test_backpressure();
    test_random_ready();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
